// File: rtl/mem_dep_pkg.sv
// Shared types and helpers for the memory dependency tracker (mem_dep_tracker).
package mem_dep_pkg;

    localparam int MD_ADDR_W    = 32;
    localparam int MD_BLK_BYTES = 4;

    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] nb;
        case (size)
            SZ_1B:   nb = 4'd1;
            SZ_2B:   nb = 4'd2;
            SZ_4B:   nb = 4'd4;
            SZ_8B:   nb = 4'd8;
            default: nb = 4'd8;
        endcase
        return nb;
    endfunction

    // One pending write: both chunks are kept so later reads can be checked against either half.
    typedef struct packed {
        logic [MD_ADDR_W-1:0]    addr1;
        logic [MD_BLK_BYTES-1:0] mask1;
        logic                    v2;
        logic [MD_ADDR_W-1:0]    addr2;
        logic [MD_BLK_BYTES-1:0] mask2;
    } dep_entry_t;

endpackage

// File: rtl/mem_chunk_split.sv
// Splits one byte access into up to two BLK_BYTES-aligned chunk descriptors.
module mem_chunk_split
    import mem_dep_pkg::*;
#(
    parameter int ADDR_W    = MD_ADDR_W,
    parameter int BLK_BYTES = MD_BLK_BYTES
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [1:0]           size,
    output logic                 size_err,
    output logic                 v1,
    output logic                 v2,
    output logic [ADDR_W-1:0]    addr1,
    output logic [ADDR_W-1:0]    addr2,
    output logic [BLK_BYTES-1:0] mask1,
    output logic [BLK_BYTES-1:0] mask2
);

    localparam int OFF_W = $clog2(BLK_BYTES);

    logic [3:0]             nbytes;
    logic [OFF_W-1:0]       off;
    logic [2*BLK_BYTES-1:0] full;
    logic [ADDR_W-1:0]      base;

    always_comb begin
        nbytes   = size_bytes(size);
        off      = addr[OFF_W-1:0];
        size_err = en && (nbytes > 4'(BLK_BYTES));
        // Byte lanes touched, laid out across two consecutive chunks.
        for (int i = 0; i < 2*BLK_BYTES; i++) begin
            full[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
        end
        base  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        v1    = en && !size_err;
        addr1 = v1 ? base : '0;
        addr2 = v1 ? base + ADDR_W'(BLK_BYTES) : '0;
        mask1 = v1 ? full[BLK_BYTES-1:0] : '0;
        mask2 = v1 ? full[2*BLK_BYTES-1:BLK_BYTES] : '0;
        v2    = v1 && (|full[2*BLK_BYTES-1:BLK_BYTES]);
    end

endmodule

// File: rtl/mem_dep_tracker.sv
// Pending-write queue with read-after-write stall; optional stall counter under MEM_DEP_STAT_EN.
module mem_dep_tracker
    import mem_dep_pkg::*;
#(
    parameter int ADDR_W    = MD_ADDR_W,
    parameter int BLK_BYTES = MD_BLK_BYTES,
    parameter int DEPTH     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       V,
    input  logic                       MEM_RD,
    input  logic                       MEM_WR,
    input  logic [ADDR_W-1:0]          RD_ADDR,
    input  logic [ADDR_W-1:0]          WR_ADDR,
    input  logic [1:0]                 SIZE,
    input  logic                       WR_DONE,
    output logic                       RD_V1_OUT,
    output logic                       RD_V2_OUT,
    output logic [ADDR_W-1:0]          RD_ADDR1_OUT,
    output logic [ADDR_W-1:0]          RD_ADDR2_OUT,
    output logic [BLK_BYTES-1:0]       RD_MASK1_OUT,
    output logic [BLK_BYTES-1:0]       RD_MASK2_OUT,
    output logic                       WR_V1_OUT,
    output logic                       WR_V2_OUT,
    output logic [ADDR_W-1:0]          WR_ADDR1_OUT,
    output logic [ADDR_W-1:0]          WR_ADDR2_OUT,
    output logic [BLK_BYTES-1:0]       WR_MASK1_OUT,
    output logic [BLK_BYTES-1:0]       WR_MASK2_OUT,
    output logic                       SIZE_ERR_OUT,
    output logic                       STALL_OUT,
    output logic [$clog2(DEPTH+1)-1:0] COUNT_OUT,
    output logic [15:0]                STALL_CNT_OUT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic rd_err, wr_err, size_err;
    logic rd_dep, full_stall, stall, push, pop;

    dep_entry_t       entry_q [DEPTH];
    dep_entry_t       entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    mem_chunk_split #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES)) u_rd_split (
        .en(V & MEM_RD), .addr(RD_ADDR), .size(SIZE), .size_err(rd_err),
        .v1(RD_V1_OUT), .v2(RD_V2_OUT), .addr1(RD_ADDR1_OUT), .addr2(RD_ADDR2_OUT),
        .mask1(RD_MASK1_OUT), .mask2(RD_MASK2_OUT)
    );

    mem_chunk_split #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES)) u_wr_split (
        .en(V & MEM_WR), .addr(WR_ADDR), .size(SIZE), .size_err(wr_err),
        .v1(WR_V1_OUT), .v2(WR_V2_OUT), .addr1(WR_ADDR1_OUT), .addr2(WR_ADDR2_OUT),
        .mask1(WR_MASK1_OUT), .mask2(WR_MASK2_OUT)
    );

    function automatic logic chunk_hit(input logic v, input logic [ADDR_W-1:0] a,
                                       input logic [BLK_BYTES-1:0] m, input dep_entry_t e);
        return v && (((a == e.addr1) && (|(m & e.mask1))) ||
                     (e.v2 && (a == e.addr2) && (|(m & e.mask2))));
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An entry being retired this cycle still blocks reads; the hazard clears one cycle later.
    always_comb begin
        rd_dep = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid_q[e]) begin
                rd_dep = rd_dep
                       | chunk_hit(RD_V1_OUT, RD_ADDR1_OUT, RD_MASK1_OUT, entry_q[e])
                       | chunk_hit(RD_V2_OUT, RD_ADDR2_OUT, RD_MASK2_OUT, entry_q[e]);
            end
        end
        size_err   = rd_err | wr_err;
        full_stall = V && MEM_WR && !size_err && (count_q == CNT_W'(DEPTH));
        stall      = rd_dep | full_stall;
        push       = WR_V1_OUT && !stall;
        pop        = WR_DONE && (count_q != '0);
    end

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        if (push) begin
            entry_d[tail_q] = '{addr1: WR_ADDR1_OUT, mask1: WR_MASK1_OUT, v2: WR_V2_OUT,
                                addr2: WR_ADDR2_OUT, mask2: WR_MASK2_OUT};
            valid_d[tail_q] = 1'b1;
            tail_d          = ptr_inc(tail_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign SIZE_ERR_OUT = size_err;
    assign STALL_OUT    = stall;
    assign COUNT_OUT    = count_q;

`ifdef MEM_DEP_STAT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CNT_OUT = stall_cnt_q;
`else
    assign STALL_CNT_OUT = '0;
`endif

endmodule

// File: tb/tb_mem_dep_tracker.sv
// Randomized bench for mem_dep_tracker against a byte-level pending-write model.
module tb_mem_dep_tracker;

    localparam int AW    = 32;
    localparam int BLK   = 4;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          V, MEM_RD, MEM_WR, WR_DONE;
    logic [AW-1:0] RD_ADDR, WR_ADDR;
    logic [1:0]    SIZE;
    logic          RD_V1_OUT, RD_V2_OUT, WR_V1_OUT, WR_V2_OUT;
    logic [AW-1:0] RD_ADDR1_OUT, RD_ADDR2_OUT, WR_ADDR1_OUT, WR_ADDR2_OUT;
    logic [BLK-1:0] RD_MASK1_OUT, RD_MASK2_OUT, WR_MASK1_OUT, WR_MASK2_OUT;
    logic          SIZE_ERR_OUT, STALL_OUT;
    logic [2:0]    COUNT_OUT;
    logic [15:0]   STALL_CNT_OUT;

    always #5 CLK = ~CLK;

    mem_dep_tracker #(.ADDR_W(AW), .BLK_BYTES(BLK), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .V(V), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .RD_ADDR(RD_ADDR), .WR_ADDR(WR_ADDR), .SIZE(SIZE), .WR_DONE(WR_DONE),
        .RD_V1_OUT(RD_V1_OUT), .RD_V2_OUT(RD_V2_OUT),
        .RD_ADDR1_OUT(RD_ADDR1_OUT), .RD_ADDR2_OUT(RD_ADDR2_OUT),
        .RD_MASK1_OUT(RD_MASK1_OUT), .RD_MASK2_OUT(RD_MASK2_OUT),
        .WR_V1_OUT(WR_V1_OUT), .WR_V2_OUT(WR_V2_OUT),
        .WR_ADDR1_OUT(WR_ADDR1_OUT), .WR_ADDR2_OUT(WR_ADDR2_OUT),
        .WR_MASK1_OUT(WR_MASK1_OUT), .WR_MASK2_OUT(WR_MASK2_OUT),
        .SIZE_ERR_OUT(SIZE_ERR_OUT), .STALL_OUT(STALL_OUT),
        .COUNT_OUT(COUNT_OUT), .STALL_CNT_OUT(STALL_CNT_OUT)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: pending writes as (start byte address, length), oldest first.
    logic [AW-1:0] mq_addr[$];
    int            mq_len[$];
    int            stall_cycles = 0;

    logic          pend_push, pend_pop, pend_stall;
    logic [AW-1:0] pend_wa;
    int            pend_len;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model_split(input logic [AW-1:0] a, input int nb,
                                        output logic [AW-1:0] a1, output logic [AW-1:0] a2,
                                        output logic [BLK-1:0] m1, output logic [BLK-1:0] m2);
        logic [AW-1:0] b;
        a1 = a & ~AW'(BLK-1);
        a2 = a1 + AW'(BLK);
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < nb; k++) begin
            b = a + AW'(k);
            if ((b & ~AW'(BLK-1)) == a1) m1[int'(b % AW'(BLK))] = 1'b1;
            else                         m2[int'(b % AW'(BLK))] = 1'b1;
        end
    endfunction

    function automatic bit overlaps(input logic [AW-1:0] r, input int rl,
                                    input logic [AW-1:0] w, input int wl);
        for (int j = 0; j < rl; j++)
            for (int k = 0; k < wl; k++)
                if (r + AW'(j) == w + AW'(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_stall_cnt();
`ifdef MEM_DEP_STAT_EN
        return 16'(stall_cycles);
`else
        return 16'h0;
`endif
    endfunction

    // Drive one cycle's inputs after the falling edge and check every output against the model.
    task automatic apply(input logic v, input logic rd, input logic wr, input logic [AW-1:0] ra,
                         input logic [AW-1:0] wa, input logic [1:0] sz, input logic done);
        int nb;
        logic err, rv, wv, dep;
        logic [AW-1:0] ra1, ra2, wa1, wa2;
        logic [BLK-1:0] rm1, rm2, wm1, wm2;
        @(negedge CLK);
        V = v; MEM_RD = rd; MEM_WR = wr; RD_ADDR = ra; WR_ADDR = wa; SIZE = sz; WR_DONE = done;
        #1;
        nb  = 1 << sz;
        err = v && (rd || wr) && (nb > BLK);
        rv  = v && rd && !err;
        wv  = v && wr && !err;
        model_split(ra, nb, ra1, ra2, rm1, rm2);
        model_split(wa, nb, wa1, wa2, wm1, wm2);
        if (!rv) begin ra1 = '0; ra2 = '0; rm1 = '0; rm2 = '0; end
        if (!wv) begin wa1 = '0; wa2 = '0; wm1 = '0; wm2 = '0; end
        dep = 1'b0;
        if (rv) foreach (mq_addr[i]) if (overlaps(ra, nb, mq_addr[i], mq_len[i])) dep = 1'b1;
        pend_stall = dep || (wv && mq_addr.size() == DEPTH);
        pend_push  = wv && !pend_stall;
        pend_pop   = done && mq_addr.size() > 0;
        pend_wa    = wa;
        pend_len   = nb;
        check_eq("size_err", SIZE_ERR_OUT, err);
        check_eq("stall", STALL_OUT, pend_stall);
        check_eq("count", COUNT_OUT, mq_addr.size());
        check_eq("stall_cnt", STALL_CNT_OUT, exp_stall_cnt());
        check_eq("rd_v1", RD_V1_OUT, rv);
        check_eq("rd_v2", RD_V2_OUT, rv && rm2 != 0);
        check_eq("rd_addr1", RD_ADDR1_OUT, ra1);
        check_eq("rd_addr2", RD_ADDR2_OUT, ra2);
        check_eq("rd_mask1", RD_MASK1_OUT, rm1);
        check_eq("rd_mask2", RD_MASK2_OUT, rm2);
        check_eq("wr_v1", WR_V1_OUT, wv);
        check_eq("wr_v2", WR_V2_OUT, wv && wm2 != 0);
        check_eq("wr_addr1", WR_ADDR1_OUT, wa1);
        check_eq("wr_addr2", WR_ADDR2_OUT, wa2);
        check_eq("wr_mask1", WR_MASK1_OUT, wm1);
        check_eq("wr_mask2", WR_MASK2_OUT, wm2);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (pend_pop) begin
            void'(mq_addr.pop_front());
            void'(mq_len.pop_front());
        end
        if (pend_push) begin
            mq_addr.push_back(pend_wa);
            mq_len.push_back(pend_len);
        end
        if (pend_stall && stall_cycles < 65535) stall_cycles++;
    endtask

    task automatic idle(input logic done);
        apply(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, done);
        tick();
    endtask

    task automatic model_reset();
        mq_addr.delete();
        mq_len.delete();
        stall_cycles = 0;
    endtask

    initial begin
        int base;
        logic [AW-1:0] ra, wa;
        RST = 1'b0; V = 0; MEM_RD = 0; MEM_WR = 0; RD_ADDR = '0; WR_ADDR = '0; SIZE = '0; WR_DONE = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle(1'b0);

        apply(1, 0, 1, '0, 32'h1002, 2'd2, 0);
        check_eq("split_wa1", WR_ADDR1_OUT, 32'h1000);
        check_eq("split_wm1", WR_MASK1_OUT, 4'b1100);
        check_eq("split_wa2", WR_ADDR2_OUT, 32'h1004);
        check_eq("split_wm2", WR_MASK2_OUT, 4'b0011);
        tick();
        apply(0, 0, 0, '0, '0, 2'd0, 0);
        check_eq("count_one", COUNT_OUT, 3'd1);
        tick();
        apply(1, 1, 0, 32'h1005, '0, 2'd0, 0);
        check_eq("raw_stall", STALL_OUT, 1'b1);
        check_eq("raw_rmask", RD_MASK1_OUT, 4'b0010);
        tick();
        apply(1, 1, 0, 32'h1005, '0, 2'd0, 1);
        check_eq("raw_stall_popcycle", STALL_OUT, 1'b1);
        tick();
        apply(1, 1, 0, 32'h1005, '0, 2'd0, 0);
        check_eq("raw_released", STALL_OUT, 1'b0);
        tick();
        apply(1, 1, 0, 32'h1008, '0, 2'd0, 0);
        check_eq("no_overlap", STALL_OUT, 1'b0);
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 0, 1, '0, 32'h2000 + 32'(16*i), 2'd2, 0);
            tick();
        end
        apply(1, 0, 1, '0, 32'h3000, 2'd2, 1);
        check_eq("full_stall", STALL_OUT, 1'b1);
        check_eq("full_count", COUNT_OUT, 3'd4);
        tick();
        apply(1, 0, 1, '0, 32'h3000, 2'd2, 0);
        check_eq("full_accept", STALL_OUT, 1'b0);
        tick();
        apply(0, 0, 0, '0, '0, 2'd0, 0);
        check_eq("full_count_after", COUNT_OUT, 3'd4);
        tick();
        repeat (DEPTH) idle(1'b1);

        apply(1, 0, 1, '0, 32'hFFFF_FFFE, 2'd2, 0);
        check_eq("wrap_wa1", WR_ADDR1_OUT, 32'hFFFF_FFFC);
        check_eq("wrap_wa2", WR_ADDR2_OUT, 32'h0);
        check_eq("wrap_wm2", WR_MASK2_OUT, 4'b0011);
        tick();
        apply(1, 1, 1, 32'h4000, 32'h4000, 2'd3, 0);
        check_eq("size_err_flag", SIZE_ERR_OUT, 1'b1);
        check_eq("size_err_nowr", WR_V1_OUT, 1'b0);
        tick();
        apply(0, 0, 0, '0, '0, 2'd0, 0);
        check_eq("size_err_noenq", COUNT_OUT, 3'd1);
        tick();

        base = stall_cycles;
        repeat (5) begin
            apply(1, 1, 0, 32'hFFFF_FFFF, '0, 2'd0, 0);
            tick();
        end
        apply(0, 0, 0, '0, '0, 2'd0, 1);
`ifdef MEM_DEP_STAT_EN
        check_eq("stall_cnt5", STALL_CNT_OUT, 16'(base + 5));
`else
        check_eq("stall_cnt_off", STALL_CNT_OUT, 16'h0);
`endif
        tick();

        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, '0, 32'h5000 + 32'(8*i), 2'd1, 0);
            tick();
        end
        apply(1, 1, 0, 32'h5000, '0, 2'd0, 0);
        #2 RST = 1'b0;
        #1;
        check_eq("rst_count", COUNT_OUT, 3'd0);
        check_eq("rst_stall", STALL_OUT, 1'b0);
        check_eq("rst_stall_cnt", STALL_CNT_OUT, 16'h0);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        apply(1, 1, 0, 32'h5000, '0, 2'd0, 0);
        check_eq("rst_empty", STALL_OUT, 1'b0);
        tick();

        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'h1000 + 32'($urandom_range(0, 23));
            wa = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'h1000 + 32'($urandom_range(0, 23));
            apply($urandom_range(0, 5) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  ra, wa, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_dep_tracker.md
Name: mem_dep_tracker

Overview:
Memory-stage-1 successor that splits each read/write into aligned chunk accesses and tracks in-flight writes in a DEPTH-entry pending-write queue. Replaces the fixed two-stage (EX/ME) write comparison with a parametrised, stateful queue checked against every outstanding write. Sits between D2 latches and the memory-stage-2 latches. Drives a stall to the pipeline on read-after-write overlap or queue full.

Parameters:
ADDR_W, 32, address width in bits
BLK_BYTES, 4, chunk size in bytes; power of two, 4 or 8; byte-mask width
DEPTH, 4, pending-write queue entries (2..16), one entry per accepted write

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
V  in  1  stage valid
MEM_RD  in  1  instruction performs a memory read
MEM_WR  in  1  instruction performs a memory write
RD_ADDR  in  ADDR_W  read byte address
WR_ADDR  in  ADDR_W  write byte address
SIZE  in  2  access size code: 0=1B, 1=2B, 2=4B, 3=8B
WR_DONE  in  1  oldest pending write committed to memory this cycle
RD_V1_OUT, RD_V2_OUT  out  1  read chunk valids
RD_ADDR1_OUT, RD_ADDR2_OUT  out  ADDR_W  read chunk base addresses (BLK-aligned)
RD_MASK1_OUT, RD_MASK2_OUT  out  BLK_BYTES  read chunk byte masks
WR_V1_OUT, WR_V2_OUT, WR_ADDR1_OUT, WR_ADDR2_OUT, WR_MASK1_OUT, WR_MASK2_OUT  out  as read  write chunk descriptors
SIZE_ERR_OUT  out  1  access size exceeds BLK_BYTES
STALL_OUT  out  1  stage must hold
COUNT_OUT  out  clog2(DEPTH+1)  occupied entries
STALL_CNT_OUT  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (RST=0, async): queue empty, head=tail=0, COUNT_OUT=0, all entry valids 0, stall counter 0. Combinational outputs 0 while V=0.
- Split (combinational, per access): off = addr mod BLK_BYTES; full = ((1<<bytes)-1)<<off over 2*BLK_BYTES bits; MASK1 = low half, MASK2 = high half; ADDR1 = addr with low bits cleared; ADDR2 = ADDR1+BLK_BYTES modulo 2^ADDR_W (top-of-space wraps to 0); V2 = MASK2!=0. V1 = V & op flag & ~SIZE_ERR.
- SIZE_ERR_OUT = V & (MEM_RD|MEM_WR) & (bytes > BLK_BYTES); access becomes no-op (no chunks, no enqueue, no stall).
- Dependency: rd_dep = any valid entry e, any read chunk c with c.v, same chunk address, (c.mask & e.mask)!=0. Both entry chunks compared. Current instruction's own write is not compared (RMW reads older state).
- full_stall = V & MEM_WR & ~SIZE_ERR & (COUNT_OUT==DEPTH), using registered count; same-cycle WR_DONE does not relieve it.
- STALL_OUT = rd_dep | full_stall. Zero-cycle latency (combinational from inputs and queue registers).
- Accept = V & ~STALL_OUT. Write accepted: push {addr1,mask1,v2,addr2,mask2} at tail, tail+1 mod DEPTH.
- WR_DONE with COUNT_OUT>0: invalidate head, head+1 mod DEPTH. WR_DONE on empty: ignored.
- Simultaneous push and pop: both occur; count unchanged. Entry being popped this cycle still counts for rd_dep (conservative).
- Pointer wrap via mod DEPTH; DEPTH need not be a power of two.

Optional Feature:
MEM_DEP_STAT_EN: defined -> STALL_CNT_OUT increments each cycle STALL_OUT=1, saturates at 0xFFFF, cleared by reset. Undefined -> STALL_CNT_OUT tied 0, no counter flops.

Decomposition:
- Package mem_dep_pkg: size-code constants, size-to-bytes function, queue entry struct {addr1, mask1, v2, addr2, mask2}.
- One sub-module: mem_chunk_split (combinational split of address+size into two chunk descriptors + SIZE_ERR), instantiated twice (read, write).

Test Plan:
- Reset mid-operation with 3 entries queued: RST=0 -> COUNT_OUT=0 immediately, STALL_OUT=0, queue empty after release.
- Write 0x1002 SIZE=2 -> WR chunk1 0x1000 mask 1100, chunk2 0x1004 mask 0011, COUNT_OUT=1 next cycle.
- Then read 0x1005 SIZE=0 -> mask 0010 @0x1004 overlaps -> STALL_OUT=1; WR_DONE pulse -> STALL_OUT=0 next cycle; read 0x1008 SIZE=0 never stalls.
- DEPTH=4: four writes fill queue, fifth write with WR_DONE same cycle -> STALL_OUT=1 that cycle, accepted next cycle, COUNT_OUT stays 4.
- Write 0xFFFFFFFE SIZE=2 -> chunk2 0x00000000 mask 0011; SIZE=3 (8B) with BLK_BYTES=4 -> SIZE_ERR_OUT=1, no enqueue.
- MEM_DEP_STAT_EN defined: 5 stall cycles -> STALL_CNT_OUT=5; undefined -> STALL_CNT_OUT=0.
